// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Programmable phase-duration timer driven by the intersection state machine.
//   It holds three duration registers (BASE, EXT, YEL) and counts down the
//   selected one in whole seconds. A one-cycle 'expired' pulse marks the end
//   of each phase.
//
// Ports
//   clk            system clock; all logic is clocked on the rising edge
//   reset          synchronous reset, active low
//   startTimer     1-cycle pulse: load the selected duration and start counting
//   timeParameter  duration select: 00 BASE, 01 EXT, 10 YEL, 11 ZERO
//   reprogram      1-cycle pulse: write prog_val into prog_sel, then abort
//   prog_sel       register select: 00 BASE, 01 EXT, 10 YEL, 11 no write
//   prog_val       new duration in seconds (0 is ignored)
//   expired        registered 1-cycle pulse at the end of a countdown
//   time_left      seconds remaining in the current phase (0 when idle)
//   running        high while a countdown is active
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int VAL_W    = 4,
  parameter int BASE_DEF = 6,
  parameter int EXT_DEF  = 3,
  parameter int YEL_DEF  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startTimer,
  input  logic [1:0]       timeParameter,
  input  logic             reprogram,
  input  logic [1:0]       prog_sel,
  input  logic [VAL_W-1:0] prog_val,
  output logic             expired,
  output logic [VAL_W-1:0] time_left,
  output logic             running
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [VAL_W-1:0] base_q, base_n;
  logic [VAL_W-1:0] ext_q, ext_n;
  logic [VAL_W-1:0] yel_q, yel_n;
  logic [VAL_W-1:0] time_left_n;
  logic             expired_n;
  logic [VAL_W-1:0] sel_val;

  // Duration chosen by timeParameter. The mux reads the registers as they
  // stand before this edge, so a same-edge write can never leak into a load.
  always_comb begin
    sel_val = '0;
    unique case (timeParameter)
      SEL_BASE: sel_val = base_q;
      SEL_EXT:  sel_val = ext_q;
      SEL_YEL:  sel_val = yel_q;
      default:  sel_val = '0;
    endcase
  end

  // Next-state logic. Priority: reprogram > startTimer > countdown
  // (reset is handled in the register process and beats all of them).
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_n     = state;
    div_n       = div;
    time_left_n = time_left;
    expired_n   = 1'b0;
    base_n      = base_q;
    ext_n       = ext_q;
    yel_n       = yel_q;

    if (reprogram) begin
      // A zero duration would make a phase indistinguishable from ZERO, so
      // it is refused and the register keeps its old value.
      if (prog_val != '0) begin
        unique case (prog_sel)
          SEL_BASE: base_n = prog_val;
          SEL_EXT:  ext_n  = prog_val;
          SEL_YEL:  yel_n  = prog_val;
          default:  ;
        endcase
      end
      // Reprogramming always abandons the current phase without an expiry;
      // a startTimer arriving in the same cycle is dropped.
      state_n     = IDLE;
      time_left_n = '0;
      div_n       = '0;
    end else if (startTimer) begin
      // Loading from any state restarts the phase; a pending expiry from
      // the previous phase is simply lost.
      state_n     = RUN;
      time_left_n = sel_val;
      div_n       = '0;
    end else if (state == RUN) begin
      if (time_left == '0) begin
        // ZERO select: expire on the very next edge.
        expired_n = 1'b1;
        state_n   = IDLE;
        div_n     = '0;
      end else if (div == TICK_LAST) begin
        div_n = '0;
        if (time_left == VAL_W'(1)) begin
          expired_n   = 1'b1;
          time_left_n = '0;
          state_n     = IDLE;
        end else begin
          time_left_n = time_left - VAL_W'(1);
        end
      end else begin
        div_n = div + DIV_W'(1);
      end
    end
  end

  // State register. Reset is synchronous and active low.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state     <= IDLE;
      div       <= '0;
      time_left <= '0;
      expired   <= 1'b0;
      base_q    <= VAL_W'(BASE_DEF);
      ext_q     <= VAL_W'(EXT_DEF);
      yel_q     <= VAL_W'(YEL_DEF);
    end else begin
      state     <= state_n;
      div       <= div_n;
      time_left <= time_left_n;
      expired   <= expired_n;
      base_q    <= base_n;
      ext_q     <= ext_n;
      yel_q     <= yel_n;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
//   Directed bench for phase_timer with TICK_DIV = 4. Inputs change and
//   outputs are sampled on the falling edge, away from the active edge.
//   "Edge k" is the rising edge that samples a startTimer pulse.
// -----------------------------------------------------------------------------
module tb_phase_timer;

  localparam int TICK_DIV = 4;
  localparam int VAL_W    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             startTimer;
  logic [1:0]       timeParameter;
  logic             reprogram;
  logic [1:0]       prog_sel;
  logic [VAL_W-1:0] prog_val;
  logic             expired;
  logic [VAL_W-1:0] time_left;
  logic             running;

  int checks = 0;
  int passes = 0;

  phase_timer #(
    .TICK_DIV (TICK_DIV),
    .VAL_W    (VAL_W),
    .BASE_DEF (6),
    .EXT_DEF  (3),
    .YEL_DEF  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .startTimer    (startTimer),
    .timeParameter (timeParameter),
    .reprogram     (reprogram),
    .prog_sel      (prog_sel),
    .prog_val      (prog_val),
    .expired       (expired),
    .time_left     (time_left),
    .running       (running)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse startTimer for one edge; returns just after edge k.
  task automatic pulse_start(input logic [1:0] sel);
    startTimer    = 1'b1;
    timeParameter = sel;
    @(negedge clk);
    startTimer    = 1'b0;
  endtask

  task automatic pulse_reprogram(input logic [1:0] sel, input logic [VAL_W-1:0] val);
    reprogram = 1'b1;
    prog_sel  = sel;
    prog_val  = val;
    @(negedge clk);
    reprogram = 1'b0;
    prog_sel  = 2'b11;
    prog_val  = '0;
  endtask

  // Cycles from edge k until expired is seen high; -1 if the budget runs out.
  task automatic measure_expiry(input int budget, output int cyc);
    cyc = 0;
    while (expired !== 1'b1 && cyc <= budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc > budget) cyc = -1;
  endtask

  task automatic test_reset;
    int cyc;
    reset = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    checks++;
    if (expired !== 1'b0) $display("FAIL reset_expired: got %b want 0", expired);
    else passes++;
    checks++;
    if (running !== 1'b0) $display("FAIL reset_running: got %b want 0", running);
    else passes++;
    checks++;
    if (time_left !== 4'd0) $display("FAIL reset_time_left: got %0d want 0", time_left);
    else passes++;
    pulse_start(2'b10);
    measure_expiry(100, cyc);
    checks++;
    if (cyc != 8) $display("FAIL reset_yel_latency: got %0d want 8", cyc);
    else passes++;
    wait_cycles(2);
  endtask

  task automatic test_yel_phase;
    pulse_start(2'b10);                       // after edge k
    checks++;
    if (time_left !== 4'd2 || running !== 1'b1)
      $display("FAIL yel_k: time_left %0d running %b want 2 1", time_left, running);
    else passes++;
    wait_cycles(3);                           // after k+3
    checks++;
    if (time_left !== 4'd2) $display("FAIL yel_k3: time_left %0d want 2", time_left);
    else passes++;
    wait_cycles(1);                           // after k+4
    checks++;
    if (time_left !== 4'd1) $display("FAIL yel_k4: time_left %0d want 1", time_left);
    else passes++;
    wait_cycles(3);                           // after k+7
    checks++;
    if (expired !== 1'b0 || running !== 1'b1)
      $display("FAIL yel_k7: expired %b running %b want 0 1", expired, running);
    else passes++;
    wait_cycles(1);                           // after k+8
    checks++;
    if (expired !== 1'b1 || running !== 1'b0 || time_left !== 4'd0)
      $display("FAIL yel_k8: expired %b running %b time_left %0d want 1 0 0",
               expired, running, time_left);
    else passes++;
    wait_cycles(1);
    checks++;
    if (expired !== 1'b0) $display("FAIL yel_k9: expired %b want 0", expired);
    else passes++;
  endtask

  task automatic test_reprogram_ext;
    int cyc;
    pulse_reprogram(2'b01, 4'd7);
    wait_cycles(1);
    pulse_start(2'b01);
    checks++;
    if (time_left !== 4'd7) $display("FAIL ext7_load: time_left %0d want 7", time_left);
    else passes++;
    measure_expiry(100, cyc);
    checks++;
    if (cyc != 28) $display("FAIL ext7_latency: got %0d want 28", cyc);
    else passes++;
    wait_cycles(2);
  endtask

  task automatic test_zero_val_ignored;
    int cyc;
    pulse_reprogram(2'b00, 4'd0);
    wait_cycles(1);
    pulse_start(2'b00);
    checks++;
    if (time_left !== 4'd6) $display("FAIL base_zero_write: time_left %0d want 6", time_left);
    else passes++;
    measure_expiry(100, cyc);
    checks++;
    if (cyc != 24) $display("FAIL base_latency: got %0d want 24", cyc);
    else passes++;
    wait_cycles(2);
  endtask

  task automatic test_zero_select;
    pulse_start(2'b11);
    checks++;
    if (time_left !== 4'd0 || running !== 1'b1 || expired !== 1'b0)
      $display("FAIL zero_k: time_left %0d running %b expired %b want 0 1 0",
               time_left, running, expired);
    else passes++;
    wait_cycles(1);
    checks++;
    if (expired !== 1'b1 || time_left !== 4'd0 || running !== 1'b0)
      $display("FAIL zero_k1: expired %b time_left %0d running %b want 1 0 0",
               expired, time_left, running);
    else passes++;
    wait_cycles(1);
    checks++;
    if (expired !== 1'b0) $display("FAIL zero_single: expired %b want 0", expired);
    else passes++;
  endtask

  task automatic test_abort;
    int pulses;
    pulse_start(2'b00);
    wait_cycles(9);
    pulse_reprogram(2'b11, 4'd5);             // sampled at cycle k+10
    checks++;
    if (running !== 1'b0 || time_left !== 4'd0)
      $display("FAIL abort_state: running %b time_left %0d want 0 0", running, time_left);
    else passes++;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (expired === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) $display("FAIL abort_no_expiry: got %0d pulses want 0", pulses);
    else passes++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int early;
    pulse_start(2'b10);
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (expired === 1'b1) early++;
      @(negedge clk);
    end
    pulse_start(2'b10);                        // second start at +6
    checks++;
    if (time_left !== 4'd2 || early != 0)
      $display("FAIL restart_load: time_left %0d early %0d want 2 0", time_left, early);
    else passes++;
    measure_expiry(100, cyc);
    checks++;
    if (cyc != 8) $display("FAIL restart_latency: got %0d want 8", cyc);
    else passes++;
    wait_cycles(2);
  endtask

  task automatic test_same_cycle;
    int cyc;
    // reprogram and startTimer together: the start is dropped, the write lands.
    reprogram     = 1'b1;
    prog_sel      = 2'b10;
    prog_val      = 4'd3;
    startTimer    = 1'b1;
    timeParameter = 2'b10;
    @(negedge clk);
    reprogram  = 1'b0;
    startTimer = 1'b0;
    prog_sel   = 2'b11;
    prog_val   = '0;
    checks++;
    if (running !== 1'b0 || time_left !== 4'd0)
      $display("FAIL same_cycle_drop: running %b time_left %0d want 0 0", running, time_left);
    else passes++;
    pulse_start(2'b10);
    checks++;
    if (time_left !== 4'd3) $display("FAIL same_cycle_write: time_left %0d want 3", time_left);
    else passes++;
    measure_expiry(100, cyc);
    checks++;
    if (cyc != 12) $display("FAIL yel3_latency: got %0d want 12", cyc);
    else passes++;
    wait_cycles(2);
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulse_start(2'b01);                        // EXT currently 7
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    checks++;
    if (running !== 1'b0 || time_left !== 4'd0)
      $display("FAIL reset_mid_state: running %b time_left %0d want 0 0", running, time_left);
    else passes++;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (expired === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses != 0) $display("FAIL reset_mid_expiry: got %0d pulses want 0", pulses);
    else passes++;
    // EXT back to its default of 3 after reset.
    pulse_start(2'b01);
    checks++;
    if (time_left !== 4'd3) $display("FAIL reset_ext_default: time_left %0d want 3", time_left);
    else passes++;
    wait_cycles(15);
  endtask

  initial begin
    reset         = 1'b0;
    startTimer    = 1'b0;
    timeParameter = 2'b00;
    reprogram     = 1'b0;
    prog_sel      = 2'b11;
    prog_val      = '0;
    @(negedge clk);
    test_reset;
    test_yel_phase;
    test_reprogram_ext;
    test_zero_val_ignored;
    test_zero_select;
    test_abort;
    test_back_to_back;
    test_same_cycle;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
